// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter that multiplexes NUM_REQ requesters onto one FIFO write port.
// Define FIFO_ARB_STATS_EN to add the saturating stall_cnt output.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [NUM_REQ-1:0]    grant_nxt;
  logic [IDX_W-1:0]      owner, owner_nxt;
  logic [IDX_W-1:0]      last_owner, last_owner_nxt;
  logic [IDX_W-1:0]      pick;
  logic [CNT_W-1:0]      beat_cnt, beat_cnt_nxt;
  logic                  accept, abandon, burst_end;
  logic [DATA_WIDTH-1:0] slice [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First requester with req high, searching upward from the one after prev.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   prev);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    logic             found;
    sel   = prev;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(prev) + k) % NUM_REQ);
      if (!found && r[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick = rr_pick(req, last_owner);

  always_comb begin
    accept         = 1'b0;
    abandon        = 1'b0;
    burst_end      = 1'b0;
    req_ack        = '0;
    fifo_wr_en     = 1'b0;
    fifo_wr_data   = '0;
    busy           = 1'b0;
    state_nxt      = state;
    grant_nxt      = grant;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt    = BURST;
          grant_nxt    = NUM_REQ'(1) << pick;
          owner_nxt    = pick;
          beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        // A reset edge is coming: present nothing so a truncated packet gets no extra beat.
        busy          = ~wr_rst;
        fifo_wr_data  = slice[owner];
        accept        = req[owner] & ~fifo_full & ~wr_rst;
        abandon       = ~req[owner] & ~fifo_full;
        burst_end     = abandon | (accept & (req_last[owner] | (beat_cnt == LAST_BEAT)));
        fifo_wr_en    = accept;
        req_ack[owner] = accept;
        if (accept) beat_cnt_nxt = beat_cnt + CNT_W'(1);
        if (burst_end) begin
          state_nxt      = IDLE;
          grant_nxt      = '0;
          last_owner_nxt = owner;
        end
      end
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      beat_cnt   <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      owner      <= owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      stall_cnt <= '0;
    end else if ((state == BURST) && req[owner] && fifo_full && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed, table-driven bench for fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=8).
module tb_fifo_write_arbiter;

  logic        wr_clk = 1'b0;
  logic        wr_rst;
  logic [3:0]  req;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic [3:0]  grant;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        busy;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fifo_write_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(8)) dut (
    .wr_clk       (wr_clk),
    .wr_rst       (wr_rst),
    .req          (req),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .grant        (grant),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       full;
    logic [3:0] grant;
    logic       en;
    logic [3:0] ack;
    logic [7:0] data;
    logic       busy;
    logic       stall_mark;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] dat [4];

  function automatic void v(input logic rst, input logic [3:0] r, input logic [3:0] l,
                            input logic f, input logic [3:0] g, input logic en,
                            input logic [3:0] a, input logic [7:0] d, input logic b,
                            input logic mark);
    vec_t x;
    x.rst = rst; x.req = r; x.last = l; x.full = f; x.grant = g; x.en = en;
    x.ack = a; x.data = d; x.busy = b; x.stall_mark = mark;
    vecs.push_back(x);
  endfunction

  function automatic void idle(input logic [3:0] r);
    v(1'b0, r, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0);
  endfunction

  function automatic void beat(input logic [3:0] r, input logic [3:0] l,
                               input logic [3:0] g, input logic [7:0] d);
    v(1'b0, r, l, 1'b0, g, 1'b1, g, d, 1'b1, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    dat[0] = 8'hA0; dat[1] = 8'hB1; dat[2] = 8'hC2; dat[3] = 8'hD3;
    req_data  = 32'hD3C2B1A0;
    wr_rst    = 1'b1;
    req       = 4'b0000;
    req_last  = 4'b0000;
    fifo_full = 1'b0;

    // Single requester, 3-beat packet, then reset in idle.
    idle(4'b0001);
    beat(4'b0001, 4'b0000, 4'b0001, 8'hA0);
    beat(4'b0001, 4'b0000, 4'b0001, 8'hA0);
    beat(4'b0001, 4'b0001, 4'b0001, 8'hA0);
    idle(4'b0000);
    v(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0);
    // All four requesting, 2-beat packets: rotation 0,1,2,3,0.
    idle(4'b1111);
    for (int r = 0; r < 4; r++) begin
      beat(4'b1111, 4'b0000, 4'(1 << r), dat[r]);
      beat(4'b1111, 4'(1 << r), 4'(1 << r), dat[r]);
      idle(4'b1111);
    end
    beat(4'b1111, 4'b0001, 4'b0001, 8'hA0);
    idle(4'b0000);
    // Requester 2 streams without last: cut at 8 beats, requester 3 next.
    idle(4'b1100);
    for (int i = 0; i < 8; i++) beat(4'b1100, 4'b0000, 4'b0100, 8'hC2);
    idle(4'b1100);
    beat(4'b1100, 4'b1000, 4'b1000, 8'hD3);
    idle(4'b0000);
    // 5-cycle FIFO-full stall mid-burst; still exactly 8 beats overall.
    idle(4'b0001);
    beat(4'b0001, 4'b0000, 4'b0001, 8'hA0);
    for (int i = 0; i < 5; i++)
      v(1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0000, 8'hA0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) beat(4'b0001, 4'b0000, 4'b0001, 8'hA0);
    v(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b1);
    // Reset on 2nd beat of requester 1, then requester 0 wins first.
    idle(4'b0010);
    beat(4'b0010, 4'b0000, 4'b0010, 8'hB1);
    v(1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0000, 8'hB1, 1'b0, 1'b0);
    idle(4'b0011);
    beat(4'b0011, 4'b0001, 4'b0001, 8'hA0);
    idle(4'b0011);
    beat(4'b0011, 4'b0010, 4'b0010, 8'hB1);
    idle(4'b0000);
    // Owner 2 abandons; requester 0 follows after one idle cycle.
    idle(4'b0101);
    beat(4'b0101, 4'b0000, 4'b0100, 8'hC2);
    v(1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0000, 8'hC2, 1'b1, 1'b0);
    idle(4'b0001);
    beat(4'b0001, 4'b0001, 4'b0001, 8'hA0);
    idle(4'b0000);

    @(negedge wr_clk);
    @(negedge wr_clk);
    #1;
    chk("reset_grant", 16'(grant), 16'h0);
    chk("reset_outs", {13'd0, fifo_wr_en, busy, |req_ack}, 16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge wr_clk);
      wr_rst    = vecs[i].rst;
      req       = vecs[i].req;
      req_last  = vecs[i].last;
      fifo_full = vecs[i].full;
      #1;
      checks++;
      if ({grant, fifo_wr_en, req_ack, fifo_wr_data, busy} !==
          {vecs[i].grant, vecs[i].en, vecs[i].ack, vecs[i].data, vecs[i].busy}) begin
        errors++;
        $display("FAIL vec%0d: got grant=%b en=%b ack=%b data=%h busy=%b, required grant=%b en=%b ack=%b data=%h busy=%b",
                 i, grant, fifo_wr_en, req_ack, fifo_wr_data, busy,
                 vecs[i].grant, vecs[i].en, vecs[i].ack, vecs[i].data, vecs[i].busy);
      end
`ifdef FIFO_ARB_STATS_EN
      if (vecs[i].stall_mark) chk("stall_cnt", stall_cnt, 16'd5);
`endif
    end

    // Owner drops req while FIFO is full: burst must hold until full clears.
    @(negedge wr_clk);
    req = 4'b0001; req_last = 4'b0000; fifo_full = 1'b0;
    #1 chk("hold_idle", {11'd0, grant, busy}, 16'h0);
    @(negedge wr_clk);
    req = 4'b0000; fifo_full = 1'b1;
    #1 chk("hold_grant1", {11'd0, grant, busy}, {11'd0, 4'b0001, 1'b1});
    chk("hold_nowr1", {11'd0, req_ack, fifo_wr_en}, 16'h0);
    @(negedge wr_clk);
    #1 chk("hold_grant2", {11'd0, grant, busy}, {11'd0, 4'b0001, 1'b1});
    @(negedge wr_clk);
    fifo_full = 1'b0;
    #1 chk("abandon_cycle", {11'd0, grant, fifo_wr_en}, {11'd0, 4'b0001, 1'b0});
    @(negedge wr_clk);
    #1 chk("abandon_done", {11'd0, grant, busy}, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
